// File: rtl/rf_access_master_pkg.sv
// Shared types for the HMC register-file access master.
package rf_access_pkg;
   localparam int RF_ERR_W = 2;

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} rf_am_state_e;

   typedef enum logic [RF_ERR_W-1:0] {
      RF_OK      = 2'b00,
      RF_INVALID = 2'b01,
      RF_TIMEOUT = 2'b10
   } rf_err_e;
endpackage

// File: rtl/rf_access_master_if.sv
// Host-side request/response channels of the register-file access master.
interface rf_access_master_if #(
   parameter int AWIDTH = 4,
   parameter int WWIDTH = 64,
   parameter int RWIDTH = 64
);
   import rf_access_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [AWIDTH-1:0]   req_addr;
   logic [WWIDTH-1:0]   req_wdata;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [RWIDTH-1:0]   rsp_rdata;
   logic [RF_ERR_W-1:0] rsp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/rf_access_master_timeout_counter.sv
// Wait-cycle counter for the access master; only built with RF_ACCESS_MASTER_TIMEOUT_EN.
`ifdef RF_ACCESS_MASTER_TIMEOUT_EN
module rf_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic res,
   input  logic clear,
   input  logic enable,
   output logic terminal
);
   logic [15:0] cnt;

   assign terminal = (cnt == 16'(TIMEOUT_CYCLES));

   // Holds at the terminal value so a stalled WAIT cannot wrap around.
   always_ff @(posedge clk) begin
      if (res || clear)
         cnt <= '0;
      else if (enable && !terminal)
         cnt <= cnt + 16'd1;
   end
endmodule
`endif

// File: rtl/rf_access_master.sv
// Single-request master for the HMC register-file port: strobe, wait for completion, respond.
// Optional wait timeout enabled by RF_ACCESS_MASTER_TIMEOUT_EN.
module rf_access_master
   import rf_access_pkg::*;
#(
   parameter int HMC_RF_WWIDTH  = 64,
   parameter int HMC_RF_RWIDTH  = 64,
   parameter int HMC_RF_AWIDTH  = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     res,
   rf_access_master_if.slave        acc,
   output logic [HMC_RF_AWIDTH-1:0] rf_address,
   output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
   output logic                     rf_read_enable,
   output logic                     rf_write_enable,
   input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
   input  logic                     rf_access_complete,
   input  logic                     rf_invalid_address
);
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("rf_access_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   rf_am_state_e state;
   rf_err_e      err_q;
   logic         wr_q;

   assign acc.req_ready = (state == IDLE) && !res;
   assign acc.rsp_error = err_q;

`ifdef RF_ACCESS_MASTER_TIMEOUT_EN
   logic timeout_hit;

   rf_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk),
      .res      (res),
      .clear    (state == STROBE),
      .enable   (state == WAIT),
      .terminal (timeout_hit)
   );
`endif

   always_ff @(posedge clk) begin
      if (res) begin
         state           <= IDLE;
         wr_q            <= 1'b0;
         err_q           <= RF_OK;
         rf_read_enable  <= 1'b0;
         rf_write_enable <= 1'b0;
         rf_address      <= '0;
         rf_write_data   <= '0;
         acc.rsp_valid   <= 1'b0;
         acc.rsp_rdata   <= '0;
      end else begin
         rf_read_enable  <= 1'b0;
         rf_write_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (acc.req_valid) begin
                  wr_q            <= acc.req_write;
                  rf_address      <= acc.req_addr;
                  // Reads leave the previous write data on the bus.
                  if (acc.req_write)
                     rf_write_data <= acc.req_wdata;
                  rf_write_enable <= acc.req_write;
                  rf_read_enable  <= !acc.req_write;
                  state           <= STROBE;
               end
            end
            STROBE: state <= WAIT;
            WAIT: begin
               if (rf_access_complete) begin
                  acc.rsp_valid <= 1'b1;
                  acc.rsp_rdata <= (!wr_q && !rf_invalid_address) ? rf_read_data : '0;
                  err_q         <= rf_invalid_address ? RF_INVALID : RF_OK;
                  state         <= RESP;
               end
`ifdef RF_ACCESS_MASTER_TIMEOUT_EN
               else if (timeout_hit) begin
                  acc.rsp_valid <= 1'b1;
                  acc.rsp_rdata <= '0;
                  err_q         <= RF_TIMEOUT;
                  state         <= RESP;
               end
`endif
            end
            RESP: begin
               if (acc.rsp_ready) begin
                  acc.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rf_access_master.sv
// Bench for rf_access_master: directed table, reset-in-WAIT sequence, randomized accesses vs a latency/data model.
module tb_rf_access_master;
   localparam int TO    = 8;
   localparam int BOUND = 40;
`ifdef RF_ACCESS_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic        wr;
      logic [3:0]  addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        inv;
      int          dly;    // completion cycle counted from the strobe cycle
      int          hold;   // cycles rsp_ready stays low in RESP
      bit          early;  // spurious completion during the strobe cycle
      bit          keep;   // keep req_valid high until the next access
      logic [1:0]  err;
      logic [63:0] rdx;
      int          lat;    // cycles from strobe to first rsp_valid
   } vec_t;

   logic        clk = 1'b0;
   logic        res;
   logic [3:0]  rf_address;
   logic [63:0] rf_write_data;
   logic [63:0] rf_read_data;
   logic        rf_read_enable, rf_write_enable;
   logic        rf_access_complete, rf_invalid_address;
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] mdl_wdata = '0;
   vec_t        tbl [9];

   rf_access_master_if #(.AWIDTH(4), .WWIDTH(64), .RWIDTH(64)) ifc ();

   rf_access_master #(
      .HMC_RF_WWIDTH(64), .HMC_RF_RWIDTH(64), .HMC_RF_AWIDTH(4), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk                (clk),
      .res                (res),
      .acc                (ifc),
      .rf_address         (rf_address),
      .rf_write_data      (rf_write_data),
      .rf_read_enable     (rf_read_enable),
      .rf_write_enable    (rf_write_enable),
      .rf_read_data       (rf_read_data),
      .rf_access_complete (rf_access_complete),
      .rf_invalid_address (rf_invalid_address)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic vec_t mk(input logic wr, input logic [3:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdata,
                               input logic inv, input int dly, input int hold,
                               input bit early, input bit keep, input logic [1:0] err,
                               input logic [63:0] rdx, input int lat);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.inv = inv;
      v.dly = dly; v.hold = hold; v.early = early; v.keep = keep;
      v.err = err; v.rdx = rdx; v.lat = lat;
      return v;
   endfunction

   // Reference: response appears one cycle after completion unless the wait limit expires first.
   function automatic vec_t with_model(input vec_t v);
      vec_t r = v;
      if (TO_EN && v.dly > TO + 1) begin
         r.err = 2'b10; r.rdx = '0; r.lat = TO + 2;
      end else begin
         r.err = v.inv ? 2'b01 : 2'b00;
         r.rdx = (!v.wr && !v.inv) ? v.rdata : 64'd0;
         r.lat = v.dly + 1;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      res = 1'b1;
      ifc.req_valid = 1'b0; ifc.rsp_ready = 1'b0;
      rf_access_complete = 1'b0; rf_invalid_address = 1'b0;
      @(negedge clk);
      res = 1'b0;
      mdl_wdata = '0;
   endtask

   // Entered and left on a falling edge.
   task automatic run_vec(input vec_t v);
      logic [63:0] exp_wd;
      int          first;
      bit          ok_bus, ok_hold;
      exp_wd = v.wr ? v.wdata : mdl_wdata;
      chk("req_ready_idle", 64'(ifc.req_ready), 64'd1);
      ifc.req_valid = 1'b1; ifc.req_write = v.wr; ifc.req_addr = v.addr; ifc.req_wdata = v.wdata;
      @(negedge clk);
      if (!v.keep) ifc.req_valid = 1'b0;
      chk("strobe", 64'({rf_write_enable, rf_read_enable}), v.wr ? 64'd2 : 64'd1);
      chk("strobe_addr", 64'(rf_address), 64'(v.addr));
      chk("strobe_wdata", rf_write_data, exp_wd);
      mdl_wdata = exp_wd;
      rf_access_complete = v.early; rf_invalid_address = v.early; rf_read_data = rnd64();
      ok_bus = 1'b1; first = 0;
      for (int c = 1; c <= BOUND; c++) begin
         @(negedge clk);
         rf_access_complete = 1'b0; rf_invalid_address = 1'b0; rf_read_data = rnd64();
         if (ifc.rsp_valid) begin
            first = c;
            break;
         end
         if (rf_read_enable || rf_write_enable || ifc.req_ready ||
             rf_address != v.addr || rf_write_data != exp_wd) ok_bus = 1'b0;
         if (c == v.dly) begin
            rf_access_complete = 1'b1; rf_invalid_address = v.inv; rf_read_data = v.rdata;
         end
      end
      chk("wait_bus_stable", 64'(ok_bus), 64'd1);
      chk("rsp_valid_seen", 64'(ifc.rsp_valid), 64'd1);
      if (first == 0) begin
         do_reset();
         return;
      end
      chk("rsp_latency", 64'(first), 64'(v.lat));
      chk("rsp_error", 64'(ifc.rsp_error), 64'(v.err));
      chk("rsp_rdata", ifc.rsp_rdata, v.rdx);
      ok_hold = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
         rf_access_complete = 1'b1; rf_invalid_address = 1'($urandom_range(0, 1));
         rf_read_data = rnd64();
         @(negedge clk);
         if (!ifc.rsp_valid || ifc.rsp_error != v.err || ifc.rsp_rdata != v.rdx ||
             ifc.req_ready || rf_read_enable || rf_write_enable || rf_address != v.addr)
            ok_hold = 1'b0;
      end
      rf_access_complete = 1'b0; rf_invalid_address = 1'b0;
      chk("rsp_hold_stable", 64'(ok_hold), 64'd1);
      ifc.rsp_ready = 1'b1;
      @(negedge clk);
      ifc.rsp_ready = 1'b0;
      chk("rsp_release", 64'({ifc.rsp_valid, ifc.req_ready}), 64'd1);
   endtask

   initial begin
      vec_t v;
      res = 1'b1;
      ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0;
      ifc.rsp_ready = 1'b0;
      rf_read_data = '0; rf_access_complete = 1'b0; rf_invalid_address = 1'b0;

      tbl[0] = mk(1'b1, 4'h3, 64'hDEAD_BEEF_0000_0001, 64'h1111, 1'b0, 2, 0, 1'b0, 1'b0,
                  2'b00, 64'd0, 3);
      tbl[1] = mk(1'b0, 4'hA, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 0, 1'b0, 1'b0,
                  2'b00, 64'h0123_4567_89AB_CDEF, 2);
      tbl[2] = mk(1'b0, 4'hF, 64'd0, 64'h5555_5555_5555_5555, 1'b1, 1, 1, 1'b0, 1'b0,
                  2'b01, 64'd0, 2);
      tbl[3] = mk(1'b0, 4'h1, 64'd0, 64'h7777_7777_7777_7777, 1'b0, 20, 3, 1'b0, 1'b0,
                  TO_EN ? 2'b10 : 2'b00, TO_EN ? 64'd0 : 64'h7777_7777_7777_7777,
                  TO_EN ? 10 : 21);
      tbl[4] = mk(1'b1, 4'h7, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0, 3, 5, 1'b0, 1'b1,
                  2'b00, 64'd0, 4);
      tbl[5] = mk(1'b0, 4'h2, 64'd0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1, 0, 1'b1, 1'b0,
                  2'b00, 64'hA5A5_A5A5_5A5A_5A5A, 2);
      tbl[6] = mk(1'b1, 4'hC, 64'h0BAD_0BAD_0BAD_0BAD, 64'h9999, 1'b1, 4, 0, 1'b0, 1'b0,
                  2'b01, 64'd0, 5);
      tbl[7] = mk(1'b0, 4'h4, 64'd0, 64'h1357_9BDF_0246_8ACE, 1'b0, 9, 1, 1'b0, 1'b0,
                  2'b00, 64'h1357_9BDF_0246_8ACE, 10);
      tbl[8] = mk(1'b0, 4'h5, 64'd0, 64'h2468_ACE0_1357_9BDF, 1'b0, 10, 2, 1'b0, 1'b0,
                  TO_EN ? 2'b10 : 2'b00, TO_EN ? 64'd0 : 64'h2468_ACE0_1357_9BDF,
                  TO_EN ? 10 : 11);

      repeat (2) @(negedge clk);
      chk("rst_req_ready_in_res", 64'(ifc.req_ready), 64'd0);
      chk("rst_flags", 64'({ifc.rsp_valid, rf_read_enable, rf_write_enable, ifc.rsp_error}), 64'd0);
      chk("rst_rsp_rdata", ifc.rsp_rdata, 64'd0);
      chk("rst_rf_address", 64'(rf_address), 64'd0);
      chk("rst_rf_write_data", rf_write_data, 64'd0);
      res = 1'b0;
      #1 chk("rst_req_ready", 64'(ifc.req_ready), 64'd1);
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // Reset while waiting for completion: access abandoned, bus cleared.
      ifc.req_valid = 1'b1; ifc.req_write = 1'b0; ifc.req_addr = 4'h5;
      @(negedge clk);
      ifc.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      chk("midrst_strobes_rsp", 64'({rf_read_enable, rf_write_enable, ifc.rsp_valid}), 64'd0);
      chk("midrst_rf_address", 64'(rf_address), 64'd0);
      chk("midrst_req_ready_in_res", 64'(ifc.req_ready), 64'd0);
      res = 1'b0; mdl_wdata = '0;
      rf_access_complete = 1'b1; rf_read_data = rnd64();
      #1 chk("midrst_req_ready", 64'(ifc.req_ready), 64'd1);
      @(negedge clk);
      rf_access_complete = 1'b0;
      chk("midrst_no_rsp", 64'(ifc.rsp_valid), 64'd0);
      run_vec(mk(1'b0, 4'h6, 64'd0, 64'hFEDC_BA98_7654_3210, 1'b0, 2, 1, 1'b0, 1'b0,
                 2'b00, 64'hFEDC_BA98_7654_3210, 3));

      for (int i = 0; i < 30; i++) begin
         v.wr    = 1'($urandom_range(0, 1));
         v.addr  = 4'($urandom_range(0, 15));
         v.wdata = rnd64();
         v.rdata = rnd64();
         v.inv   = ($urandom_range(0, 3) == 0);
         v.dly   = $urandom_range(1, 12);
         v.hold  = $urandom_range(0, 3);
         v.early = ($urandom_range(0, 3) == 0);
         v.keep  = (i != 29) && ($urandom_range(0, 3) == 0);
         run_vec(with_model(v));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rf_access_master.md
# rf_access_master

Request-driven master for the HMC controller register-file port. It accepts single read/write requests from a host or configuration sequencer over a valid/ready channel and drives the register-file bus: address, write data, and read/write enables. It waits for access completion, then returns a response with read data and an error code over a second valid/ready channel. It sits directly upstream of the controller register file and is the only driver of that bus.

## Interface
- HMC_RF_WWIDTH, 64, write data width
- HMC_RF_RWIDTH, 64, read data width
- HMC_RF_AWIDTH, 4, register address width
- TIMEOUT_CYCLES, 255, maximum wait cycles after the enable pulse; must be ≥1 and < 2^16
- clk  in  1  single clock; all logic is on the rising edge
- res  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  HMC_RF_AWIDTH  register address
- req_wdata  in  HMC_RF_WWIDTH  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  HMC_RF_RWIDTH  read data; 0 for writes and errors
- rsp_error  out  2  00 ok, 01 invalid address, 10 timeout
- rf_address  out  HMC_RF_AWIDTH  register-file address
- rf_write_data  out  HMC_RF_WWIDTH  register-file write data
- rf_read_enable  out  1  one-cycle read strobe
- rf_write_enable  out  1  one-cycle write strobe
- rf_read_data  in  HMC_RF_RWIDTH  register-file read data
- rf_access_complete  in  1  access done (pulse)
- rf_invalid_address  in  1  qualifies rf_access_complete

## Operation
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, register addr, wdata and write; go to STROBE.
- STROBE (exactly 1 cycle): assert rf_write_enable or rf_read_enable, never both. Clear the timeout counter. Go to WAIT. rf_access_complete in this cycle is ignored.
- WAIT: rf_address and rf_write_data are held stable. The counter increments by 1 per cycle.
  - On rf_access_complete: capture rf_read_data (reads without invalid address only; otherwise 0). Set rsp_error = 01 if rf_invalid_address, else 00. Go to RESP.
  - Counter reaches TIMEOUT_CYCLES without completion: rsp_error=10, rsp_rdata=0, go to RESP.
  - Completion and timeout in the same cycle: completion wins.
- RESP: rsp_valid=1; rsp_rdata and rsp_error are stable until the handshake. On rsp_ready, go to IDLE.
- rf_access_complete outside WAIT (including late completion after timeout) is ignored.
- rf_address and rf_write_data keep their last values in IDLE/RESP. Reads drive rf_write_data with the held old value.
- Outside IDLE, req_ready=0 and no request is captured.

## Timing
- Reset values (cycle after res sampled high):
  - state IDLE
  - rf_read_enable, rf_write_enable, rsp_valid = 0
  - rsp_rdata, rsp_error, rf_address, rf_write_data = 0
  - req_ready = 0 while res is high, then 1 in IDLE.
- Accept at edge T → strobe high during cycle T+1 → earliest completion sampled at edge T+2 → rsp_valid from cycle T+3.
- Response consumed at edge R → req_ready=1 in cycle R+1. Maximum throughput is one access per 4 cycles.
- Timeout: with no completion, rsp_valid rises TIMEOUT_CYCLES+2 cycles after the strobe cycle.
- All outputs are registered except req_ready (decoded from state and res).
- Reset mid-access: the access is abandoned with no response, strobes drop, and the state is IDLE next cycle.

## Configuration
- RF_ACCESS_MASTER_TIMEOUT_EN:
  - Defined: timeout counter present, error 10 possible.
  - Undefined: counter removed, WAIT lasts until rf_access_complete indefinitely, rsp_error[1] is tied 0, and TIMEOUT_CYCLES is unused.

## Structure
- Package rf_access_pkg:
  - state enum rf_am_state_e (IDLE, STROBE, WAIT, RESP)
  - error enum rf_err_e (RF_OK=2'b00, RF_INVALID=2'b01, RF_TIMEOUT=2'b10)
  - RF_ERR_W=2
- Sub-module rf_timeout_counter: clear, enable, terminal-count output; parameterised by TIMEOUT_CYCLES. It is instantiated only under RF_ACCESS_MASTER_TIMEOUT_EN.

## Test plan
- Write addr 4'h3 data 64'hDEAD_BEEF_0000_0001, slave completes 2 cycles after the strobe → one write_enable pulse, address and data stable through WAIT, response rsp_error=00 rsp_rdata=0.
- Read addr 4'hA, slave returns 64'h0123_4567_89AB_CDEF with complete at the earliest cycle → rsp_rdata matches, rsp_valid at T+3, read_enable pulse 1 cycle.
- Read addr 4'hF with complete and invalid_address → rsp_error=01, rsp_rdata=0.
- TIMEOUT_CYCLES=8, no completion → rsp_error=10 exactly 10 cycles after the strobe; a late complete in RESP has no effect.
- Response backpressure: rsp_ready low for 5 cycles with req_valid held high → req_ready stays 0, response is stable, the next request is accepted the cycle after the handshake.
- res pulsed in WAIT → strobes 0, no rsp_valid, req_ready=1 the cycle after res deasserts, and a new read completes normally.
